// File: rtl/product_accumulator.sv
// Accumulates N_TERMS 4-bit products per frame and presents the sum on a valid/ready port.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp SUM on overflow instead of wrapping.
module product_accumulator #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 6,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [3:0]       P,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] SUM,
  output logic [CNT_W-1:0] COUNT,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {S_ACC, S_HOLD} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   add_w;
  logic             carry_w, take_w, last_w;

  assign add_w   = {1'b0, sum_q} + {{(ACC_W-3){1'b0}}, P};
  assign carry_w = add_w[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  assign sum_d   = carry_w ? {ACC_W{1'b1}} : add_w[ACC_W-1:0];
`else
  assign sum_d   = add_w[ACC_W-1:0];
`endif
  assign ovf_d   = ovf_q | carry_w;
  assign cnt_d   = cnt_q + 1'b1;
  assign take_w  = (state_q == S_ACC) && in_valid;
  assign last_w  = (cnt_d == CNT_W'(N_TERMS));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= S_ACC;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_ACC: if (take_w) begin
          sum_q <= sum_d;
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
          if (last_w) state_q <= S_HOLD;
        end
        // Hand-off starts a fresh frame; in_valid is ignored while holding.
        S_HOLD: if (out_ready) begin
          state_q <= S_ACC;
          sum_q   <= '0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_HOLD);
  assign SUM       = sum_q;
  assign COUNT     = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized self-checking bench for product_accumulator against a frame-level integer model.
module tb_product_accumulator;
  localparam int N = 8;
  localparam int AW = 6;
  localparam int CW = $clog2(N + 1);
  localparam int MAXV = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, out_ready;
  logic [3:0]    P;
  logic          in_ready, ovf, out_valid;
  logic [AW-1:0] SUM;
  logic [CW-1:0] COUNT;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: true (unbounded) frame total, accepted-term count, presenting flag.
  int m_sum = 0;
  int m_cnt = 0;
  bit m_hold = 0;

  product_accumulator #(.N_TERMS(N), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .P(P), .in_valid(in_valid), .in_ready(in_ready),
    .SUM(SUM), .COUNT(COUNT), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int exp_sum();
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    return (m_sum > MAXV) ? MAXV : m_sum;
`else
    return m_sum % (MAXV + 1);
`endif
  endfunction

  function automatic bit exp_ovf();
    return m_sum > MAXV;
  endfunction

  // Drive one cycle's inputs from a negedge, apply the model at the edge, return at next negedge.
  task automatic step(input bit r, input bit c, input bit v, input int p, input bit ordy);
    rst = r; clr = c; in_valid = v; P = 4'(p); out_ready = ordy;
    @(posedge clk);
    if (r || c) begin
      m_sum = 0; m_cnt = 0; m_hold = 0;
    end else if (m_hold) begin
      if (ordy) begin m_sum = 0; m_cnt = 0; m_hold = 0; end
    end else if (v) begin
      m_sum += p; m_cnt++;
      if (m_cnt == N) m_hold = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 1, 5, 0);
    step(1, 0, 1, 5, 0);
    n_checks++; if (SUM !== '0) $display("FAIL reset_sum: got %0d want 0", SUM); else n_pass++;
    n_checks++; if (COUNT !== '0) $display("FAIL reset_count: got %0d want 0", COUNT); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_full_frame();
    for (int i = 1; i <= N; i++) begin
      step(0, 0, 1, i, 1);
      if (i == N - 1) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL frame_early_valid: got %b want 0", out_valid); else n_pass++;
      end
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL frame_out_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (SUM !== AW'(36)) $display("FAIL frame_sum: got %0d want 36", SUM); else n_pass++;
    n_checks++; if (COUNT !== CW'(N)) $display("FAIL frame_count: got %0d want %0d", COUNT, N); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL frame_ovf: got %b want 0", ovf); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL frame_in_ready_hold: got %b want 0", in_ready); else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++; if (SUM !== '0 || COUNT !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL frame_after_handoff: got sum=%0d cnt=%0d rdy=%b vld=%b want 0 0 1 0", SUM, COUNT, in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int want;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    want = 63;
`else
    want = 8;
`endif
    for (int i = 0; i < N; i++) step(0, 0, 1, 9, 0);
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf); else n_pass++;
    n_checks++; if (SUM !== AW'(want)) $display("FAIL ovf_sum: got %0d want %0d", SUM, want); else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) step(0, 0, 1, $urandom_range(0, 9), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 7, 0);
      n_checks++;
      if (SUM !== AW'(exp_sum()) || in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL bp_hold%0d: got sum=%0d rdy=%b vld=%b want %0d 0 1", i, SUM, in_ready, out_valid, exp_sum());
      else n_pass++;
    end
    step(0, 0, 1, 7, 1);
    n_checks++; if (SUM !== '0 || COUNT !== '0) $display("FAIL bp_handoff: got sum=%0d cnt=%0d want 0 0", SUM, COUNT); else n_pass++;
    for (int i = 0; i < N; i++) step(0, 0, 1, $urandom_range(0, 9), 0);
    n_checks++;
    if (SUM !== AW'(exp_sum()) || ovf !== exp_ovf()) $display("FAIL bp_next_frame: got sum=%0d ovf=%b want %0d %b", SUM, ovf, exp_sum(), exp_ovf());
    else n_pass++;
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 4, 0);
    n_checks++; if (SUM !== AW'(12) || COUNT !== CW'(3)) $display("FAIL abort_pre: got sum=%0d cnt=%0d want 12 3", SUM, COUNT); else n_pass++;
    step(0, 1, 1, 2, 0);
    n_checks++; if (SUM !== '0 || COUNT !== '0 || in_ready !== 1'b1) $display("FAIL abort_acc: got sum=%0d cnt=%0d rdy=%b want 0 0 1", SUM, COUNT, in_ready); else n_pass++;
    for (int i = 0; i < N; i++) step(0, 0, 1, 5, 0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL abort_fill: got %b want 1", out_valid); else n_pass++;
    step(0, 1, 0, 0, 0);
    n_checks++; if (out_valid !== 1'b0 || SUM !== '0 || COUNT !== '0) $display("FAIL abort_hold: got vld=%b sum=%0d cnt=%0d want 0 0 0", out_valid, SUM, COUNT); else n_pass++;
  endtask

  task automatic test_gaps();
    for (int t = 1; t <= N; t++) begin
      int g = $urandom_range(0, 4);
      for (int k = 0; k < g; k++) begin
        step(0, 0, 0, $urandom_range(0, 15), 0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL gaps_idle_valid: got %b want 0", out_valid); else n_pass++;
      end
      step(0, 0, 1, 3, 0);
      n_checks++;
      if (out_valid !== (t == N)) $display("FAIL gaps_term%0d_valid: got %b want %b", t, out_valid, (t == N));
      else n_pass++;
    end
    n_checks++; if (SUM !== AW'(24)) $display("FAIL gaps_sum: got %0d want 24", SUM); else n_pass++;
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(0, ($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
      n_checks++;
      if (SUM !== AW'(exp_sum()) || COUNT !== CW'(m_cnt) || ovf !== exp_ovf() ||
          out_valid !== m_hold || in_ready !== !m_hold)
        $display("FAIL random_c%0d: got sum=%0d cnt=%0d ovf=%b vld=%b rdy=%b want %0d %0d %b %b %b",
                 i, SUM, COUNT, ovf, out_valid, in_ready, exp_sum(), m_cnt, exp_ovf(), m_hold, !m_hold);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; P = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_overflow();
    test_backpressure();
    test_abort();
    test_gaps();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential stage that sits directly downstream of the 2-bit multiplier/2:1 multiplexer datapath. It consumes the 4-bit selected product `P` one term per accepted handshake and sums a frame of `N_TERMS` products into an `ACC_W`-bit accumulator. It then presents the frame result on a valid/ready output port and holds it until the consumer takes it. It turns the combinational product stream into a registered dot-product-style result.

## Interface

**Parameters**
- `N_TERMS`, default 8: products per frame; legal range ≥ 2.
- `ACC_W`, default 6: accumulator and `SUM` width; legal range ≥ 4.
- `CNT_W`, default `$clog2(N_TERMS+1)`: width of `COUNT`.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `clr`, input, 1: synchronous frame abort; lower priority than `rst`.
- `P`, input, 4: product term taken from the upstream mux output `Y`.
- `in_valid`, input, 1: `P` is valid this cycle.
- `in_ready`, output, 1: block accepts a term this cycle.
- `SUM`, output, `ACC_W`: running or final accumulated value, registered.
- `COUNT`, output, `CNT_W`: terms accepted in the current frame, registered.
- `ovf`, output, 1: sticky overflow for the current frame, registered.
- `out_valid`, output, 1: `SUM` holds a completed frame result.
- `out_ready`, input, 1: consumer takes the result.

## Operation

**States**
- `ACC`: accepting terms.
- `HOLD`: presenting the result.

**Reset (`rst` = 1 at an edge)**
- State goes to `ACC`.
- `SUM` = 0, `COUNT` = 0, `ovf` = 0, `out_valid` = 0.
- `in_ready` reads 1 from the first cycle after reset.

**Outputs by state**
- `in_ready` = 1 exactly when state is `ACC`; it is combinational from state only.
- `out_valid` = 1 exactly when state is `HOLD`.

**Transfer in `ACC`**
- A term transfers when `in_valid` and `in_ready` are both 1.
- On transfer: `SUM` ← `SUM` + zero-extended `P`, and `COUNT` ← `COUNT` + 1.
- A carry out of bit `ACC_W`-1 sets `ovf`.
- `ovf` stays set until the frame is handed off, `clr` is asserted, or `rst` is asserted.
- When the transfer makes `COUNT` equal to `N_TERMS`, the next state is `HOLD`.
- With `in_valid` = 0, state and outputs hold; gaps of any length are legal.

**Hand-off in `HOLD`**
- `SUM`, `COUNT` (= `N_TERMS`) and `ovf` are frozen.
- `in_valid` is ignored and no term is consumed.
- When `out_ready` = 1, the next state is `ACC` with `SUM` = 0, `COUNT` = 0, `ovf` = 0.

**Frame abort (`clr` = 1, `rst` = 0)**
- State, `SUM`, `COUNT` and `ovf` take the reset values in either state.
- A term offered in the same cycle is discarded.
- A held result is dropped without a hand-off.

**Arithmetic**
- The sum is unsigned.
- `P` has range 0..9; a value above 9 is still added as is, with no range check.

## Timing

- **Input latency:** a term accepted at edge k is reflected in `SUM`/`COUNT` after edge k.
- **Result latency:** `out_valid` rises in the cycle after the edge that accepts term `N_TERMS`. `SUM` is final in that same cycle.
- **Input throughput:** one term per cycle while in `ACC`.
- **Frame throughput:** one frame per `N_TERMS` + 1 cycles minimum. This assumes `out_ready` is held at 1, which gives a single `HOLD` cycle.
- **No overlap:** `in_ready` is 0 for every cycle of `HOLD`. The first term of the next frame is accepted no earlier than the cycle after hand-off.
- **`out_ready` = 1 during `ACC`:** no effect.
- **Priority at an edge:** `rst` > `clr` > hand-off/transfer.

## Configuration

Macro: `PRODUCT_ACCUMULATOR_SATURATE_EN`

- **Defined:** an addition that overflows clamps `SUM` at 2^`ACC_W` − 1 and sets `ovf`. Later terms in the frame keep `SUM` clamped.
- **Not defined:** `SUM` wraps modulo 2^`ACC_W` and `ovf` is still set on carry-out.
- The interface and timing are identical in both builds.

## Test plan

1. **Reset:** hold `rst` = 1 for 2 cycles with `in_valid` = 1 and `P` = 5 → `SUM` = 0, `COUNT` = 0, `ovf` = 0, `out_valid` = 0; `in_ready` = 1 from the first cycle after reset.
2. **Full frame:** defaults; stream `P` = 1..8 on consecutive cycles with `out_ready` = 1 → `out_valid` = 1 for one cycle, in the cycle after term 8, with `SUM` = 36, `COUNT` = 8, `ovf` = 0. The next cycle shows `SUM` = 0, `COUNT` = 0, `in_ready` = 1.
3. **Overflow:** defaults; 8 terms of `P` = 9 → `ovf` = 1. Without the macro, `SUM` = 8 (72 mod 64). With the macro, `SUM` = 63.
4. **Backpressure:** complete a frame, hold `out_ready` = 0 for 5 cycles while driving `in_valid` = 1 with `P` = 7 → `SUM` stays frozen and `in_ready` = 0 for all 5 cycles. Raising `out_ready` gives a hand-off and a clean next frame that does not include the ignored 7s.
5. **Abort:** accept 3 terms (`P` = 4, 4, 4; `SUM` = 12), then assert `clr` together with `in_valid` and `P` = 2 → `SUM` = 0 and `COUNT` = 0, and the 2 is not added. Asserting `clr` during `HOLD` drops the result, and `out_valid` falls in the next cycle.
6. **Gaps:** 8 terms of `P` = 3 with random `in_valid` gaps of 0–4 cycles → `SUM` = 24 and `out_valid` rises exactly one cycle after the eighth accepted term.
